// File: rtl/reg_load_seq.sv
// reg_load_seq: serial-to-bank load sequencer.
//
// Walks a one-hot enable across a bank of N single-bit registers. Each
// accepted serial bit raises exactly one enable. The shared data line d_out
// carries that bit, so register i captures din at the same clock edge
// (zero latency). When the word is complete, done pulses for one cycle.
//
// Optional feature macro: PARITY_EN
//   defined   - after the N data bits, one extra serial bit is consumed as an
//               even-parity bit in a PAR state. parity_err is registered at
//               that edge, is valid with done, and holds until the next start.
//   undefined - no PAR state and no accumulator; parity_err is tied to 0.

module reg_load_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic         bit_valid,
    input  logic         din,
    output logic [N-1:0] en,
    output logic         d_out,
    output logic         busy,
    output logic         done,
    output logic         parity_err
);

    localparam int               IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [N-1:0]     EN_ONE   = N'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
`ifdef PARITY_EN
    localparam logic [1:0] S_PAR  = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [IDX_W-1:0] idx;
    logic             load_go;
    logic             accept;
    logic             last_bit;

    // A start is honoured only from IDLE; it also re-arms index and parity.
    assign load_go  = (state == S_IDLE) && start;

    // A bit is written only in LOAD, and abort suppresses it in the same cycle.
    assign accept   = (state == S_LOAD) && bit_valid && !abort;
    assign last_bit = accept && (idx == LAST_IDX);

    // Next-state selection; abort wins over every other input in LOAD/PAR.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (last_bit) begin
`ifdef PARITY_EN
                    state_nxt = S_PAR;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
`ifdef PARITY_EN
            S_PAR: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (bit_valid) begin
                    state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Register index: cleared on start, advances per accepted bit, saturates at N-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else if (load_go) begin
            idx <= '0;
        end else if (accept && (idx != LAST_IDX)) begin
            idx <= idx + 1'b1;
        end
    end

`ifdef PARITY_EN
    logic acc;
    logic perr_q;

    // Running XOR of the data bits written into the bank.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= 1'b0;
        end else if (load_go) begin
            acc <= 1'b0;
        end else if (accept) begin
            acc <= acc ^ din;
        end
    end

    // Parity verdict: set at the PAR edge and held until the next start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perr_q <= 1'b0;
        end else if (load_go) begin
            perr_q <= 1'b0;
        end else if ((state == S_PAR) && bit_valid && !abort) begin
            perr_q <= acc ^ din;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    // Mealy enable: the selected register sees its enable in the strobe cycle.
    assign en    = accept ? (EN_ONE << idx) : '0;
    assign d_out = (state == S_LOAD) ? din : 1'b0;
    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);

endmodule

// File: tb/tb_reg_load_seq.sv
// Bench for reg_load_seq: directed vectors with a scoreboard. Stimulus pushes
// the expected bit writes and completed words into queues. A monitor on the
// falling edge pops and compares whenever the DUT raises an enable or done.
// The bench also models the register bank the sequencer drives.

module tb_reg_load_seq;

    localparam int           N      = 8;
    localparam logic [N-1:0] EN_ONE = N'(1);

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         bit_valid = 1'b0;
    logic         din = 1'b0;
    logic [N-1:0] en;
    logic         d_out;
    logic         busy;
    logic         done;
    logic         parity_err;

    logic [N-1:0] bank;
    logic         bank_clr = 1'b1;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int done_exp = 0;

    logic [N:0] bit_q[$];
    logic [N:0] done_q[$];
    logic [N:0] mon_b;
    logic [N:0] mon_d;

    reg_load_seq #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .bit_valid  (bit_valid),
        .din        (din),
        .en         (en),
        .d_out      (d_out),
        .busy       (busy),
        .done       (done),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Register bank driven by the sequencer's enables and shared data line.
    always @(posedge clk) begin
        if (bank_clr) begin
            bank <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (en[i]) bank[i] <= d_out;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every enable and every done pulse is checked against the queues.
    always @(negedge clk) begin
        if (en != '0) begin
            if (bit_q.size() == 0) begin
                chk("stray_en", 32'(en), 32'd0);
            end else begin
                mon_b = bit_q.pop_front();
                chk("bit_write", 32'({en, d_out}), 32'(mon_b));
            end
        end
        if (done) begin
            done_seen++;
            if (done_q.size() == 0) begin
                chk("stray_done", 32'(done), 32'd0);
            end else begin
                mon_d = done_q.pop_front();
                chk("done_word", 32'(bank), 32'(mon_d[N:1]));
                chk("done_parity", 32'(parity_err), 32'(mon_d[0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bank();
        bank_clr = 1'b1;
        step();
        bank_clr = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_en", 32'(en), 32'd0);
    endtask

    task automatic send_bit(input int i, input logic b);
        bit_valid = 1'b1;
        din = b;
        bit_q.push_back({EN_ONE << i, b});
        step();
        bit_valid = 1'b0;
        din = 1'b0;
    endtask

    task automatic expect_word(input logic [N-1:0] w, input logic p);
        done_q.push_back({w, p});
        done_exp++;
    endtask

    task automatic send_word(input logic [N-1:0] w);
        for (int i = 0; i < N; i++) send_bit(i, w[i]);
    endtask

    // Parity bit (when compiled in), then the done cycle with a start poke.
    task automatic finish_word(input logic p);
`ifdef PARITY_EN
        bit_valid = 1'b1;
        din = p;
        #1;
        chk("par_en", 32'(en), 32'd0);
        step();
        bit_valid = 1'b0;
        din = 1'b0;
`else
        din = p & 1'b0;
`endif
        #1;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        chk("post_done_busy", 32'(busy), 32'd0);
        chk("post_done_done", 32'(done), 32'd0);
        step();
        #1;
        chk("start_in_done_ignored", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held low with start and bit_valid asserted.
        start = 1'b1;
        bit_valid = 1'b1;
        din = 1'b1;
        repeat (3) begin
            step();
            #1;
            chk("rst_en", 32'(en), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_perr", 32'(parity_err), 32'd0);
        end
        start = 1'b0;
        bit_valid = 1'b0;
        din = 1'b0;
        #1 reset = 1'b1;
        step();
        bank_clr = 1'b0;

        // bit_valid in IDLE is ignored.
        bit_valid = 1'b1;
        din = 1'b1;
        repeat (2) begin
            #1;
            chk("idle_en", 32'(en), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            step();
        end
        bit_valid = 1'b0;
        din = 1'b0;

        // Normal back-to-back load of 8'hB2.
        clear_bank();
        expect_word(8'hB2, 1'b0);
        do_start();
        send_word(8'hB2);
        finish_word(1'b0);

        // Gapped strobes with a start poke during LOAD.
        clear_bank();
        expect_word(8'hB2, 1'b0);
        do_start();
        for (int i = 0; i < N; i++) begin
            send_bit(i, (i == 1 || i == 4 || i == 5 || i == 7) ? 1'b1 : 1'b0);
            if (i < N - 1) begin
                for (int g = 0; g < 2; g++) begin
                    if (i == 3 && g == 0) start = 1'b1;
                    #1;
                    chk("gap_en", 32'(en), 32'd0);
                    chk("gap_busy", 32'(busy), 32'd1);
                    step();
                    start = 1'b0;
                end
            end
        end
        finish_word(1'b0);

        // Abort after three bits, with a strobe in the abort cycle.
        clear_bank();
        do_start();
        send_bit(0, 1'b1);
        send_bit(1, 1'b1);
        send_bit(2, 1'b1);
        abort = 1'b1;
        bit_valid = 1'b1;
        din = 1'b1;
        #1;
        chk("abort_en", 32'(en), 32'd0);
        step();
        abort = 1'b0;
        bit_valid = 1'b0;
        din = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bank", 32'(bank), 32'h07);
        step();

        // Reload after abort starts again at register 0.
        expect_word(8'h3C, 1'b0);
        do_start();
        send_word(8'h3C);
        finish_word(1'b0);

        // Asynchronous reset mid-load.
        clear_bank();
        do_start();
        send_bit(0, 1'b1);
        send_bit(1, 1'b0);
        bit_valid = 1'b1;
        din = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("midrst_en", 32'(en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        step();
        bit_valid = 1'b0;
        din = 1'b0;
        reset = 1'b1;
        step();
        #1;
        chk("midrst_idle", 32'(busy), 32'd0);
        chk("midrst_bank", 32'(bank), 32'h01);

`ifdef PARITY_EN
        // Wrong parity bit: error flagged, held, then cleared by start.
        clear_bank();
        expect_word(8'hB2, 1'b1);
        do_start();
        send_word(8'hB2);
        finish_word(1'b1);
        step();
        #1;
        chk("perr_hold", 32'(parity_err), 32'd1);
        do_start();
        chk("perr_clear", 32'(parity_err), 32'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
`endif

        repeat (3) step();
        chk("bits_drained", 32'(bit_q.size()), 32'd0);
        chk("done_drained", 32'(done_q.size()), 32'd0);
        chk("done_count", 32'(done_seen), 32'(done_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_load_seq.md
# reg_load_seq

Sequencer that loads a bank of N single-bit enable registers from a serial bit stream. It tracks which register is next, drives that register's one-hot enable and shared data line for each accepted bit, and reports completion. It sits between a serial source (keypad/UART-style strobe) and the bank of 1-bit enable flip-flops that form the project's data word.

## Interface
- N, 8, number of target registers (bits per word); N >= 2
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- start  in  1  begin a load; sampled only in IDLE
- abort  in  1  cancel load in progress; priority over every other input
- bit_valid  in  1  strobe: din holds a valid bit this cycle
- din  in  1  serial data bit, LSB (register 0) first
- en  out  N  one-hot enable to register bank; bit i drives register i
- d_out  out  1  shared data to all registers' d inputs
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse, word complete
- parity_err  out  1  parity check result (see Configuration)

## Operation
- States: IDLE, LOAD, PAR (only with PARITY_EN), DONE.
- IDLE: busy=0, en=0. start=1 -> LOAD, idx=0, parity accumulator=0, parity_err cleared.
- LOAD: en[idx]=bit_valid (Mealy, combinational), d_out=din; on clk edge with bit_valid: accumulator ^= din, idx++.
- idx==N-1 with bit_valid -> PAR (PARITY_EN) or DONE; idx does not wrap past N-1.
- PAR: en=0; on bit_valid: parity_err <= accumulator ^ din (even parity; error if 1) -> DONE.
- DONE: done=1, busy=1, en=0 for exactly one cycle -> IDLE.
- start outside IDLE ignored; bit_valid in IDLE/DONE ignored (en stays 0).
- abort=1 in LOAD/PAR: en forced 0 in that same cycle (the bit is not written), next state IDLE, no done pulse, parity_err unchanged. abort in IDLE/DONE has no effect; DONE completes.
- Registers already written before abort keep their values; sequencer never clears the bank.
- Counter width: $clog2(N) bits.

## Timing
- Reset values: state=IDLE, idx=0, en=0, d_out=0 (d_out follows din only in LOAD, else 0), busy=0, done=0, parity_err=0.
- start at edge k -> busy=1 from cycle k+1; first bit can be accepted in cycle k+1.
- Bit write: en[i] high in the same cycle as bit_valid; target register captures din at that edge (zero latency).
- Minimum load: N cycles of back-to-back bit_valid (N+1 with PARITY_EN); done high in the cycle after the edge accepting the last bit; busy drops the cycle after done.
- start asserted during done cycle is ignored; earliest restart is the cycle after done.
- reset low mid-load: outputs return to reset values immediately (asynchronous), no done.

## Configuration
- PARITY_EN defined: PAR state compiled in; one extra serial bit after the N data bits is consumed as an even-parity bit; parity_err registered at the PAR edge, valid with done, held until next start.
- PARITY_EN undefined: no PAR state, no accumulator; LOAD goes directly to DONE; parity_err tied to 0.

## Test plan
- Reset: hold reset low 3 cycles with start=1, bit_valid=1 -> en=0, busy=0, done=0, parity_err=0 throughout.
- Normal load, N=8: start, then 8 back-to-back bits of 8'hB2 LSB first -> en walks 0x01..0x80 one per cycle, d_out matches din, bank reads 0xB2, done one pulse after 8th bit, busy low next cycle.
- Gapped strobes: same word with bit_valid low 2 cycles between bits -> en=0 during gaps, idx holds, same final 0xB2 and single done.
- Abort: start, 3 bits, then abort with bit_valid=1 -> en=0 that cycle, IDLE next cycle, no done; new start then loads from en[0].
- Ignored inputs: start pulsed during LOAD and during done -> no idx reset, no extra done; bit_valid in IDLE -> en stays 0.
- PARITY_EN: 8'hB2 (four ones) + parity 0 -> parity_err=0 at done; repeat with parity 1 -> parity_err=1, held until next start clears it.
